acc_cpu_mc: RTL and testbench
=============================

Name: acc_cpu_mc

Overview:
- Multicycle, parametrised successor to the single-cycle 8-bit accumulator core.
- Generic DATA_W accumulator and ADDR_W address space.
- Instruction and data memories are external, each on a req/ack handshake, so wait-state memories are tolerated.
- Adds self-jump halt detection and a retired-instruction counter. Sits at the top of the core; memories and testbench attach to its ports.

Parameters:
- DATA_W, 8, accumulator / data memory word width (>=4)
- ADDR_W, 5, instruction and data address width; instruction word = 3 + ADDR_W bits
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  ADDR_W  fetch address (= PC)
- imem_ack_i  in  1  fetch complete; imem_data_i valid this cycle
- imem_data_i  in  3+ADDR_W  instruction word {op[2:0], arg[ADDR_W-1:0]}
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  1 = write (ST), 0 = read
- dmem_addr_o  out  ADDR_W  data address (= arg)
- dmem_wdata_o  out  DATA_W  write data (= ACC)
- dmem_ack_i  in  1  access complete; dmem_rdata_i valid on reads
- dmem_rdata_i  in  DATA_W  read data
- acc_o  out  DATA_W  accumulator
- flags_o  out  2  {C,Z}: [1] carry/borrow, [0] zero
- pc_o  out  ADDR_W  program counter
- ir_o  out  3+ADDR_W  instruction register
- halted_o  out  1  core halted
- retired_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous, when rst_i sampled high):
  - PC=0, ACC=0, flags=0, IR=0, retired=0, halted_o=0, state=FETCH.
  - All req/we outputs 0 on the cycle after reset is sampled.
  - Reset overrides any in-flight access; a late ack arriving after reset is ignored.
- Opcodes:
  - 000 LD: ACC=mem
  - 001 ST: mem=ACC
  - 010 ADD: ACC=ACC+mem
  - 011 SUB: ACC=ACC-mem
  - 100 AND: ACC=ACC&mem
  - 101 JMP
  - 110 JZ: jump if Z
  - 111 JC: jump if C
- State machine (FETCH, DECODE, MEM, HALT):
  - FETCH: imem_req_o=1, imem_addr_o=PC held stable until ack. On ack: IR<=imem_data_i, go to DECODE.
  - DECODE:
    - Jumps: if taken, PC<=arg, else PC<=PC+1; retired++; go to FETCH.
    - JMP with arg==PC: enter HALT instead. Retired increments; PC unchanged.
    - Conditional self-jumps spin; they do not halt.
    - Others: go to MEM.
  - MEM: dmem_req_o=1, with addr/we/wdata stable until ack. On ack: update ACC/flags per op, PC<=PC+1, retired++, go to FETCH.
  - HALT: halted_o=1, no requests issued; exit only via reset.
- Handshake:
  - An ack may arrive in the same cycle req is first asserted (zero-wait).
  - req drops the cycle after ack.
  - Ack without req is ignored.
  - Wait-state count is unbounded; no timeout.
- Latency (zero-wait memories): jump 2 cycles; memory op 3 cycles.
- Arithmetic:
  - ADD: C = carry out of bit DATA_W-1.
  - SUB: C = borrow (1 iff ACC < mem, unsigned).
  - AND and LD: C unchanged.
  - Z = (new ACC == 0) for LD/ADD/SUB/AND.
  - ST and jumps leave flags and ACC unchanged.
- Wrap rules:
  - PC increment wraps modulo 2^ADDR_W (PC=max -> 0).
  - retired wraps modulo 2^CNT_W.
- Flags read by JZ/JC are the values committed by the previous instruction.

Decomposition:
- Package acc_cpu_pkg:
  - opcode localparams (OP_LD..OP_JC)
  - state encoding (ST_FETCH, ST_DECODE, ST_MEM, ST_HALT)
  - flag bit indices (FLG_Z=0, FLG_C=1)
- Sub-module acc_alu_p, purely combinational:
  - parameters: DATA_W
  - inputs: op, a, b, C-in
  - outputs: result, next {C,Z}, write-enable for flags
- FSM, PC, ACC and counter live in acc_cpu_mc.

Test Plan (DATA_W=8, ADDR_W=5, zero-wait memories unless stated):
- Reset: hold rst_i 2 cycles mid-MEM access with dmem_req_o=1 -> next cycle all outputs 0, state FETCH, late ack has no effect.
- Program LD 3 (mem[3]=0xF0); ADD 4 (mem[4]=0x20) -> ACC=0x10, C=1, Z=0, retired=2, 6 cycles after reset release.
- SUB to zero: ACC=0x05, SUB mem=0x05 -> ACC=0, Z=1, C=0; then JZ 10 -> PC=10. Repeat with 0x04-0x05 -> ACC=0xFF, C=1.
- Wait states: imem_ack delayed 3 cycles, dmem_ack delayed 2 cycles on ST 7 -> req/addr/wdata stable throughout; mem[7]=ACC written once; req low the cycle after ack.
- PC wrap: ADD placed at 31 -> next fetch address 0.
- Halt: JMP 6 located at address 6 -> halted_o=1 two cycles after its fetch ack, no further requests for 20 cycles, retired count frozen. JZ to self with Z=0 falls through; with Z=1 it spins without halting.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multicycle accumulator core: opcodes, FSM states,
// flag bit positions and a small opcode classifier.
package acc_cpu_pkg;

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_ST  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_JC  = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_MEM    = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;

  // JMP, JZ and JC are the only opcodes with op[2] set and a non-zero low pair.
  function automatic logic is_jump(input logic [2:0] op);
    return op[2] && (op[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/acc_alu_p.sv
// Combinational ALU for the accumulator core: produces the new ACC value, the
// next {C,Z} flags and a write-enable telling the core whether ACC/flags change.
module acc_alu_p
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] result_o,
  output logic [1:0]        flags_o,
  output logic              flags_we_o
);

  logic [DATA_W:0] wide;
  logic            carry;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wide       = '0;
    result_o   = a_i;
    carry      = c_i;
    flags_we_o = 1'b0;
    case (op_i)
      OP_LD: begin
        result_o   = b_i;
        flags_we_o = 1'b1;
      end
      OP_ADD: begin
        wide       = {1'b0, a_i} + {1'b0, b_i};
        result_o   = wide[DATA_W-1:0];
        carry      = wide[DATA_W];
        flags_we_o = 1'b1;
      end
      OP_SUB: begin
        // The top bit of the widened difference is set exactly when a < b (borrow).
        wide       = {1'b0, a_i} - {1'b0, b_i};
        result_o   = wide[DATA_W-1:0];
        carry      = wide[DATA_W];
        flags_we_o = 1'b1;
      end
      OP_AND: begin
        result_o   = a_i & b_i;
        flags_we_o = 1'b1;
      end
      default: ;
    endcase
    flags_o        = '0;
    flags_o[FLG_C] = carry;
    flags_o[FLG_Z] = (result_o == '0);
  end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator core with req/ack instruction and data memory ports,
// self-jump halt detection and a retired-instruction counter.
module acc_cpu_mc
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [ADDR_W-1:0]   imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [ADDR_W+2:0]   imem_data_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  input  logic                dmem_ack_i,
  input  logic [DATA_W-1:0]   dmem_rdata_i,
  output logic [DATA_W-1:0]   acc_o,
  output logic [1:0]          flags_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ADDR_W+2:0]   ir_o,
  output logic                halted_o,
  output logic [CNT_W-1:0]    retired_o
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [1:0]          flags_q, flags_d;
  logic [ADDR_W+2:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [2:0]          op;
  logic [ADDR_W-1:0]   arg;
  logic [DATA_W-1:0]   alu_result;
  logic [1:0]          alu_flags;
  logic                alu_we;
  logic                taken;

  assign op  = ir_q[ADDR_W+2:ADDR_W];
  assign arg = ir_q[ADDR_W-1:0];

  acc_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op_i       (op),
    .a_i        (acc_q),
    .b_i        (dmem_rdata_i),
    .c_i        (flags_q[FLG_C]),
    .result_o   (alu_result),
    .flags_o    (alu_flags),
    .flags_we_o (alu_we)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    taken     = (op == OP_JMP)
             || ((op == OP_JZ) && flags_q[FLG_Z])
             || ((op == OP_JC) && flags_q[FLG_C]);
    case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_jump(op)) begin
          retired_d = retired_q + CNT_W'(1);
          // Only an unconditional self-jump halts; conditional ones keep spinning.
          if ((op == OP_JMP) && (arg == pc_q)) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = taken ? arg : pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (dmem_ack_i) begin
          if (alu_we) begin
            acc_d   = alu_result;
            flags_d = alu_flags;
          end
          pc_d      = pc_q + ADDR_W'(1);
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state flops use non-blocking assignment so all updates land together at the edge.
    if (rst_i) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      acc_q     <= '0;
      flags_q   <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Requests stay low while reset is held, so no access starts during reset.
  assign imem_req_o   = (state_q == ST_FETCH) && !rst_i;
  assign imem_addr_o  = pc_q;
  assign dmem_req_o   = (state_q == ST_MEM) && !rst_i;
  assign dmem_we_o    = dmem_req_o && (op == OP_ST);
  assign dmem_addr_o  = arg;
  assign dmem_wdata_o = acc_q;
  assign acc_o        = acc_q;
  assign flags_o      = flags_q;
  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign halted_o     = (state_q == ST_HALT);
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Scoreboard bench for acc_cpu_mc: bench memories with programmable wait states,
// a retire monitor checking PC/ACC/flags/count, and directed programs.
module tb_acc_cpu_mc;
  import acc_cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       imem_req_o, imem_ack_i;
  logic [4:0] imem_addr_o;
  logic [7:0] imem_data_i;
  logic       dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [4:0] dmem_addr_o;
  logic [7:0] dmem_wdata_o, dmem_rdata_i;
  logic [7:0] acc_o;
  logic [1:0] flags_o;
  logic [4:0] pc_o;
  logic [7:0] ir_o;
  logic       halted_o;
  logic [15:0] retired_o;

  always #5 clk = ~clk;

  acc_cpu_mc #(.DATA_W(8), .ADDR_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .acc_o(acc_o), .flags_o(flags_o), .pc_o(pc_o), .ir_o(ir_o),
    .halted_o(halted_o), .retired_o(retired_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  pc;
    logic [7:0]  acc;
    logic [1:0]  flg;
    logic [15:0] ret;
  } exp_t;
  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wq[$];
  logic sb_en = 1'b1;

  task automatic push_exp(input logic [4:0] pc, input logic [7:0] acc,
                          input logic [1:0] flg, input logic [15:0] ret);
    exp_t e;
    e.pc = pc; e.acc = acc; e.flg = flg; e.ret = ret;
    exp_q.push_back(e);
  endtask

  // Bench memories: ack is decided on the falling edge and sampled on the next rising edge.
  logic [7:0] rom [32];
  logic [7:0] dmem [32];
  int   imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0, w7_count = 0;
  logic iack = 1'b0, dack = 1'b0, late_ack = 1'b0;
  logic [7:0] idata = '0, rdata = '0;

  assign imem_ack_i   = iack;
  assign imem_data_i  = idata;
  assign dmem_ack_i   = dack | late_ack;
  assign dmem_rdata_i = rdata;

  always @(negedge clk) begin
    if (iack) check("imem_req_drop", {31'd0, imem_req_o}, 32'd0);
    if (dack) check("dmem_req_drop", {31'd0, dmem_req_o}, 32'd0);
    iack = 1'b0;
    dack = 1'b0;
    if (imem_req_o) begin
      if (icnt >= imem_wait) begin
        iack  = 1'b1;
        idata = rom[imem_addr_o];
        icnt  = 0;
      end else icnt++;
    end else icnt = 0;
    if (dmem_req_o) begin
      if (dmem_we_o) begin
        if (wq.size() > 0) begin
          check("st_addr", {27'd0, dmem_addr_o}, {27'd0, wq[0].a});
          check("st_wdata", {24'd0, dmem_wdata_o}, {24'd0, wq[0].d});
        end else begin
          checks++; errors++;
          $display("FAIL st_unexpected addr=%0h data=%0h required=no write", dmem_addr_o, dmem_wdata_o);
        end
      end
      if (dcnt >= dmem_wait) begin
        dack = 1'b1;
        dcnt = 0;
        if (dmem_we_o) begin
          dmem[dmem_addr_o] = dmem_wdata_o;
          if (dmem_addr_o == 5'd7) w7_count++;
          if (wq.size() > 0) void'(wq.pop_front());
        end else rdata = dmem[dmem_addr_o];
      end else dcnt++;
    end else dcnt = 0;
  end

  // Retire monitor: every change of the counter pops one expected architectural state.
  logic [15:0] prev_ret = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) prev_ret = '0;
    else if (retired_o != prev_ret) begin
      prev_ret = retired_o;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_extra_retire retired=%0d required=none pc=%0h", retired_o, pc_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", {27'd0, pc_o}, {27'd0, e.pc});
          check("sb_acc", {24'd0, acc_o}, {24'd0, e.acc});
          check("sb_flags", {30'd0, flags_o}, {30'd0, e.flg});
          check("sb_retired", {16'd0, retired_o}, {16'd0, e.ret});
        end
      end
    end
  end

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] arg);
    return {op, arg};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      rom[i]  = ins(OP_JMP, 5'(i));
      dmem[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
  endtask

  task automatic wait_retired(input int n);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      if (retired_o == 16'(n)) done = 1;
    end
    if (!done) check("wait_retired_timeout", 32'(retired_o), 32'(n));
  endtask

  task automatic wait_halt();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (halted_o) done = 1;
    end
    if (!done) check("wait_halt_timeout", {31'd0, halted_o}, 32'd1);
  endtask

  task automatic wait_sb_empty();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) check("sb_drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    // Test 1: reset values, LD/ADD timing and halt two cycles after the self-jump fetch.
    clear_mem();
    rom[0] = ins(OP_LD, 5'd3);
    rom[1] = ins(OP_ADD, 5'd4);
    dmem[3] = 8'hF0;
    dmem[4] = 8'h20;
    push_exp(5'd1, 8'hF0, 2'b00, 16'd1);
    push_exp(5'd2, 8'h10, 2'b10, 16'd2);
    push_exp(5'd2, 8'h10, 2'b10, 16'd3);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_imem_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_acc", {24'd0, acc_o}, 32'd0);
    check("rst_pc", {27'd0, pc_o}, 32'd0);
    check("rst_retired", {16'd0, retired_o}, 32'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("t1_ret_c5", {16'd0, retired_o}, 32'd1);
    check("t1_acc_c5", {24'd0, acc_o}, 32'hF0);
    @(negedge clk); #1;
    check("t1_ret_c6", {16'd0, retired_o}, 32'd2);
    check("t1_acc_c6", {24'd0, acc_o}, 32'h10);
    check("t1_flags_c6", {30'd0, flags_o}, 32'b10);
    @(negedge clk); #1;
    check("t1_not_halted_c7", {31'd0, halted_o}, 32'd0);
    @(negedge clk); #1;
    check("t1_halted_c8", {31'd0, halted_o}, 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Test 2: reset held two cycles during a stalled ADD, with a late ack around release.
    push_exp(5'd1, 8'hF0, 2'b00, 16'd1);
    do_reset();
    wait_retired(1);
    dmem_wait = 100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (dmem_req_o) seen = 1;
    end
    if (!seen) check("t2_mem_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("t2_rst_imem_req", {31'd0, imem_req_o}, 32'd0);
    check("t2_rst_dmem_req", {31'd0, dmem_req_o}, 32'd0);
    check("t2_rst_dmem_we", {31'd0, dmem_we_o}, 32'd0);
    check("t2_rst_acc", {24'd0, acc_o}, 32'd0);
    check("t2_rst_flags", {30'd0, flags_o}, 32'd0);
    check("t2_rst_pc", {27'd0, pc_o}, 32'd0);
    check("t2_rst_ir", {24'd0, ir_o}, 32'd0);
    check("t2_rst_halted", {31'd0, halted_o}, 32'd0);
    check("t2_rst_retired", {16'd0, retired_o}, 32'd0);
    late_ack = 1'b1;
    dmem_wait = 0;
    @(posedge clk); #1 rst_i = 1'b0;
    push_exp(5'd1, 8'hF0, 2'b00, 16'd1);
    push_exp(5'd2, 8'h10, 2'b10, 16'd2);
    push_exp(5'd2, 8'h10, 2'b10, 16'd3);
    @(posedge clk); #1 late_ack = 1'b0;
    @(negedge clk); #1;
    check("t2_late_ack_acc", {24'd0, acc_o}, 32'd0);
    check("t2_late_ack_pc", {27'd0, pc_o}, 32'd0);
    check("t2_late_ack_ir", {24'd0, ir_o}, 32'h03);
    check("t2_late_ack_dreq", {31'd0, dmem_req_o}, 32'd0);
    wait_halt();
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Test 3: SUB to zero, JZ taken, borrow, JC taken, JZ fall-through, JZ self-spin.
    clear_mem();
    rom[0]  = ins(OP_LD, 5'd8);
    rom[1]  = ins(OP_SUB, 5'd9);
    rom[2]  = ins(OP_JZ, 5'd10);
    rom[10] = ins(OP_LD, 5'd12);
    rom[11] = ins(OP_SUB, 5'd9);
    rom[12] = ins(OP_JC, 5'd20);
    rom[20] = ins(OP_JZ, 5'd20);
    rom[21] = ins(OP_AND, 5'd13);
    rom[22] = ins(OP_JZ, 5'd22);
    dmem[8]  = 8'h05;
    dmem[9]  = 8'h05;
    dmem[12] = 8'h04;
    dmem[13] = 8'h00;
    push_exp(5'd1,  8'h05, 2'b00, 16'd1);
    push_exp(5'd2,  8'h00, 2'b01, 16'd2);
    push_exp(5'd10, 8'h00, 2'b01, 16'd3);
    push_exp(5'd11, 8'h04, 2'b00, 16'd4);
    push_exp(5'd12, 8'hFF, 2'b10, 16'd5);
    push_exp(5'd20, 8'hFF, 2'b10, 16'd6);
    push_exp(5'd21, 8'hFF, 2'b10, 16'd7);
    push_exp(5'd22, 8'h00, 2'b11, 16'd8);
    push_exp(5'd22, 8'h00, 2'b11, 16'd9);
    push_exp(5'd22, 8'h00, 2'b11, 16'd10);
    push_exp(5'd22, 8'h00, 2'b11, 16'd11);
    do_reset();
    wait_sb_empty();
    sb_en = 1'b0;
    check("t3_spin_not_halted", {31'd0, halted_o}, 32'd0);
    check("t3_spin_pc", {27'd0, pc_o}, 32'd22);

    // Test 4: wait states on both memories, ST write, PC wrap, halt at a self-jump.
    clear_mem();
    rom[0]  = ins(OP_JC, 5'd6);
    rom[1]  = ins(OP_LD, 5'd1);
    rom[2]  = ins(OP_ST, 5'd7);
    rom[3]  = ins(OP_JMP, 5'd31);
    rom[31] = ins(OP_ADD, 5'd2);
    rom[6]  = ins(OP_JMP, 5'd6);
    dmem[1] = 8'hFF;
    dmem[2] = 8'h01;
    imem_wait = 3;
    dmem_wait = 2;
    w7_count = 0;
    do_reset();
    sb_en = 1'b1;
    push_exp(5'd1,  8'h00, 2'b00, 16'd1);
    push_exp(5'd2,  8'hFF, 2'b00, 16'd2);
    push_exp(5'd3,  8'hFF, 2'b00, 16'd3);
    push_exp(5'd31, 8'hFF, 2'b00, 16'd4);
    push_exp(5'd0,  8'h00, 2'b11, 16'd5);
    push_exp(5'd6,  8'h00, 2'b11, 16'd6);
    push_exp(5'd6,  8'h00, 2'b11, 16'd7);
    wq.push_back('{a: 5'd7, d: 8'hFF});
    wait_retired(5);
    check("t4_wrap_fetch_req", {31'd0, imem_req_o}, 32'd1);
    check("t4_wrap_fetch_addr", {27'd0, imem_addr_o}, 32'd0);
    wait_halt();
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t4_wq_empty", 32'(wq.size()), 32'd0);
    check("t4_write_once", 32'(w7_count), 32'd1);
    check("t4_mem7", {24'd0, dmem[7]}, 32'hFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("t4_halt_no_ireq", {31'd0, imem_req_o}, 32'd0);
      check("t4_halt_no_dreq", {31'd0, dmem_req_o}, 32'd0);
      check("t4_halt_held", {31'd0, halted_o}, 32'd1);
      check("t4_halt_retired", {16'd0, retired_o}, 32'd7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
